plab4_net_reorder_buf: RTL and testbench
========================================

# plab4_net_reorder_buf

Ejection-side reorder buffer for the ring network. It sits between a router's terminal output port and the local consumer. Messages from a source arrive out of order, so the buffer holds them and releases them strictly in opaque-sequence order. The sender tags each message with an incrementing opaque sequence number and keeps at most `p_num_entries` messages in flight.

## Interface
Parameters:
- `p_payload_nbits`, 8, payload field width
- `p_opaque_nbits`, 8, opaque field width; the opaque field is the sequence number
- `p_srcdest_nbits`, 3, src/dest field widths
- `p_num_entries`, 4, buffer depth; power of two, 2..2^`p_opaque_nbits`/2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_val`  in  1  message from the router terminal output is valid
- `in_rdy`  out  1  buffer accepts the message
- `in_msg`  in  `VC_NET_MSG_NBITS(p,o,s)`  net message (dest, src, opaque, payload)
- `out_val`  out  1  in-order message is available
- `out_rdy`  in  1  consumer accepts the message
- `out_msg`  out  `VC_NET_MSG_NBITS(p,o,s)`  in-order message, passed through unmodified
- `occ`  out  clog2(`p_num_entries`)+1  number of occupied entries
- `err`  out  1  sticky protocol-error flag

## Operation
- State:
  - `exp_seq`, `p_opaque_nbits` bits: the next sequence number to release.
  - `p_num_entries` slots, each holding a valid bit and a message.
- Slot index: `seq mod p_num_entries`, i.e. the low clog2(N) bits of the sequence number.
- Window: `d = (opaque − exp_seq) mod 2^o`. The message is in-window when `d < p_num_entries`. Subtraction is modular, so wrap from 0xff to 0x00 is seamless.
- Input:
  - `in_rdy` is 1 whenever `reset` is deasserted.
  - On `in_val`, an in-window message whose slot is empty is written to its slot and the valid bit is set.
  - An out-of-window message is dropped and `err` is set.
  - An in-window message whose slot is already valid is a duplicate; it is dropped and `err` is set. The stored copy is kept.
- Output:
  - `out_val` = valid bit of slot[`exp_seq`].
  - `out_msg` = that slot's message, read combinationally from the storage.
- Release: on `out_val && out_rdy`, the head slot's valid bit is cleared and `exp_seq` is incremented modulo 2^o.
- Simultaneous accept and release: both happen in the same cycle.
  - The window check always uses the pre-edge `exp_seq`, so a slot freed this cycle cannot be refilled until the next cycle.
  - Accept and release can never target the same slot.
- `occ` is the population count of the valid bits, updated every edge (+1 accept, −1 release, net 0 when both occur).
- `err` clears only on reset.
- Reset asserted mid-operation: all valid bits clear immediately and buffered messages are discarded. The sender must also restart.

## Timing
- Reset values: `exp_seq`=0, all slots invalid, `out_val`=0, `occ`=0, `err`=0, `in_rdy`=0 while `reset` is low.
- Latency: a head message accepted at edge t shows `out_val`=1 in the cycle after t (1 cycle minimum). A non-head message waits until all earlier sequence numbers are released.
- `out_val` and `out_msg` stay stable while `out_rdy`=0.
- Throughput: one release per cycle when the head is present and `out_rdy`=1.
- Output combinational paths: `in_rdy` and `out_val` have no combinational dependence on `in_val`/`out_rdy` (except under the bypass below).

## Configuration
- `PLAB4_NET_REORDER_BYPASS_EN` defined:
  - When `in_val` carries `opaque == exp_seq`, the head slot is empty and `out_rdy`=1, the message passes combinationally: `out_val`=1, `out_msg`=`in_msg`.
  - The message is not written to storage, `exp_seq` increments, and `occ` is unchanged. Latency is 0 cycles.
  - If `out_rdy`=0, the message is stored normally.
- Undefined: no combinational path from input to output; minimum latency is 1 cycle.

## Test plan
- In order, no stall: opaque 0x00,0x01,0x02,0x03 on consecutive cycles, `out_rdy`=1 → out sequence 0x00..0x03, each one cycle after its accept, `err`=0.
- Reversed arrival: opaque 0x03,0x02,0x01,0x00 → nothing out until 0x00 arrives. Then 0x00,0x01,0x02,0x03 release on consecutive cycles; `occ` peaks at 4.
- Wrap-around: start `exp_seq` at 0xfe (run 254 messages in order first), then send 0x00,0xff,0xfe → released 0xfe,0xff,0x00.
- Errors:
  - With `exp_seq`=0x00, send 0x04 → dropped, `err`=1, `occ`=0.
  - Send 0x01 twice → second copy dropped, `err`=1, first copy kept.
- Backpressure and reset: hold `out_rdy`=0 with 0x00,0x01 buffered → `out_msg` stays 0x00. Pull `reset` low for one cycle → `out_val`=0, `occ`=0, `exp_seq`=0.
- Bypass (macro defined): `exp_seq`=0x00, empty buffer, `out_rdy`=1, send 0x00 → `out_val`=1 in the same cycle with `out_msg`=`in_msg`, `occ` stays 0. Without the macro, the same stimulus gives `out_val` one cycle later.

Source files
------------

// File: rtl/plab4_net_reorder_buf.sv
// Ejection-side reorder buffer: accepts net messages out of order and
// releases them strictly in opaque-sequence order.
// Optional feature: define PLAB4_NET_REORDER_BYPASS_EN to let a head
// message pass straight through to the consumer with zero latency.
// Message layout (MSB..LSB): dest, src, opaque, payload.

module plab4_net_reorder_buf #(
  parameter int unsigned p_payload_nbits = 8,
  parameter int unsigned p_opaque_nbits  = 8,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_num_entries   = 4,
  localparam int unsigned c_msg_nbits = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits,
  localparam int unsigned c_occ_nbits = $clog2(p_num_entries) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [c_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [c_msg_nbits-1:0] out_msg,
  output logic [c_occ_nbits-1:0] occ,
  output logic                   err
);

  localparam int unsigned c_idx_nbits = $clog2(p_num_entries);
  localparam logic [p_opaque_nbits-1:0] c_num_entries = p_opaque_nbits'(p_num_entries);

  logic [c_msg_nbits-1:0]    data_q [p_num_entries];
  logic [p_num_entries-1:0]  valid_q, valid_d;
  logic [p_opaque_nbits-1:0] exp_seq_q, exp_seq_d;
  logic [c_occ_nbits-1:0]    occ_q, occ_d;
  logic                      err_q, err_d;

  logic [p_opaque_nbits-1:0] in_opaque;
  logic [p_opaque_nbits-1:0] in_dist;
  logic                      in_window;
  logic [c_idx_nbits-1:0]    in_idx;
  logic [c_idx_nbits-1:0]    head_idx;
  logic                      head_val;
  logic                      bypass;
  logic                      accept;
  logic                      drop;
  logic                      release_stored;
  logic                      advance;

  assign in_opaque = in_msg[p_payload_nbits +: p_opaque_nbits];
  // Modular distance keeps the window check seamless across sequence wrap.
  assign in_dist   = in_opaque - exp_seq_q;
  assign in_window = (in_dist < c_num_entries);
  assign in_idx    = in_opaque[c_idx_nbits-1:0];
  assign head_idx  = exp_seq_q[c_idx_nbits-1:0];
  assign head_val  = valid_q[head_idx];

  // The buffer never stalls the router; it drops bad messages instead.
  assign in_rdy = reset;

`ifdef PLAB4_NET_REORDER_BYPASS_EN
  // Head message arriving into an empty head slot with a ready consumer skips storage.
  assign bypass = in_val && in_rdy && (in_dist == '0) && !head_val && out_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign accept         = in_val && in_rdy && in_window && !valid_q[in_idx] && !bypass;
  // Out-of-window or duplicate: the stored copy (if any) is kept.
  assign drop           = in_val && in_rdy && !(in_window && !valid_q[in_idx]);
  assign release_stored = head_val && out_rdy;
  assign advance        = release_stored || bypass;

  assign out_val = head_val || bypass;
  assign out_msg = bypass ? in_msg : data_q[head_idx];
  assign occ     = occ_q;
  assign err     = err_q;

  // Next-state for slot valid bits, head pointer, occupancy and error flag.
  always_comb begin
    valid_d   = valid_q;
    exp_seq_d = exp_seq_q;
    occ_d     = occ_q;
    err_d     = err_q | drop;
    // Accept targets an empty slot, release a full one, so they never collide.
    if (release_stored) valid_d[head_idx] = 1'b0;
    if (accept)         valid_d[in_idx]   = 1'b1;
    if (advance)        exp_seq_d = exp_seq_q + 1'b1;
    unique case ({accept, release_stored})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      exp_seq_q <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      exp_seq_q <= exp_seq_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  // Payload storage; contents are only meaningful under the matching valid bit.
  always_ff @(posedge clk) begin
    if (accept) data_q[in_idx] <= in_msg;
  end

endmodule

// File: tb/tb_plab4_net_reorder_buf.sv
// Directed self-checking bench for plab4_net_reorder_buf (default parameters).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_plab4_net_reorder_buf;

  localparam int unsigned MsgNbits = 22;
  localparam int unsigned OccNbits = 3;

  logic                clk;
  logic                reset;
  logic                in_val;
  logic                in_rdy;
  logic [MsgNbits-1:0] in_msg;
  logic                out_val;
  logic                out_rdy;
  logic [MsgNbits-1:0] out_msg;
  logic [OccNbits-1:0] occ;
  logic                err;

  int num_vec;
  int num_err;

  plab4_net_reorder_buf dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .occ     (occ),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dest=5, caller-chosen src, opaque, payload derived from opaque.
  function automatic logic [MsgNbits-1:0] mk(input logic [7:0] opq, input logic [2:0] src);
    return {3'd5, src, opq, opq ^ 8'h5a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_vec++;
    if (got !== exp) begin
      num_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] opq, input logic [2:0] src);
    in_val = 1'b1;
    in_msg = mk(opq, src);
    cyc();
  endtask

  task automatic do_reset();
    in_val = 1'b0;
    reset  = 1'b0;
    cyc();
    reset  = 1'b1;
  endtask

  initial begin
    num_vec = 0;
    num_err = 0;
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_val", out_val, 0);
    check("rst_occ", occ, 0);
    check("rst_err", err, 0);
    cyc();
    reset = 1'b1;
    #1;
    check("in_rdy_up", in_rdy, 1);

    // In order, no stall: each message out one cycle after its accept.
    for (int i = 0; i < 4; i++) begin
      send(8'(i), 3'd1);
      check("inord_val", out_val, 1);
      check("inord_msg", out_msg, mk(8'(i), 3'd1));
      check("inord_occ", occ, 1);
    end
    in_val = 1'b0;
    cyc();
    check("inord_drain_val", out_val, 0);
    check("inord_drain_occ", occ, 0);
    check("inord_err", err, 0);

    // Reversed arrival: nothing out until 0x00 lands, then four back-to-back releases.
    do_reset();
    for (int i = 3; i >= 1; i--) begin
      send(8'(i), 3'd2);
      check("rev_hold_val", out_val, 0);
      check("rev_hold_occ", occ, 32'(4 - i));
    end
    send(8'h00, 3'd2);
    check("rev_head_val", out_val, 1);
    check("rev_head_msg", out_msg, mk(8'h00, 3'd2));
    check("rev_peak_occ", occ, 4);
    in_val = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("rev_rel_val", out_val, 1);
      check("rev_rel_msg", out_msg, mk(8'(i), 3'd2));
      check("rev_rel_occ", occ, 32'(4 - i));
    end
    cyc();
    check("rev_empty_val", out_val, 0);
    check("rev_empty_occ", occ, 0);
    check("rev_err", err, 0);

    // Wrap-around: advance exp_seq to 0xfe, then send 0x00, 0xff, 0xfe.
    do_reset();
    for (int i = 0; i < 254; i++) send(8'(i), 3'd3);
    in_val = 1'b0;
    cyc();
    check("wrap_pre_occ", occ, 0);
    send(8'h00, 3'd3);
    check("wrap_00_val", out_val, 0);
    send(8'hff, 3'd3);
    check("wrap_ff_val", out_val, 0);
    check("wrap_ff_occ", occ, 2);
    send(8'hfe, 3'd3);
    check("wrap_fe_msg", out_msg, mk(8'hfe, 3'd3));
    check("wrap_fe_occ", occ, 3);
    in_val = 1'b0;
    cyc();
    check("wrap_rel_ff", out_msg, mk(8'hff, 3'd3));
    cyc();
    check("wrap_rel_00", out_msg, mk(8'h00, 3'd3));
    check("wrap_rel_val", out_val, 1);
    cyc();
    check("wrap_end_val", out_val, 0);
    check("wrap_err", err, 0);

    // Out-of-window drop.
    do_reset();
    out_rdy = 1'b0;
    send(8'h04, 3'd4);
    in_val = 1'b0;
    check("oow_err", err, 1);
    check("oow_occ", occ, 0);
    check("oow_val", out_val, 0);

    // Duplicate drop keeps the first copy; err is sticky.
    do_reset();
    check("dup_err_clr", err, 0);
    send(8'h01, 3'd1);
    check("dup_first_err", err, 0);
    send(8'h01, 3'd6);
    check("dup_err", err, 1);
    check("dup_occ", occ, 1);
    send(8'h00, 3'd1);
    in_val  = 1'b0;
    check("dup_head_msg", out_msg, mk(8'h00, 3'd1));
    check("dup_occ2", occ, 2);
    out_rdy = 1'b1;
    cyc();
    check("dup_kept_msg", out_msg, mk(8'h01, 3'd1));
    cyc();
    check("dup_err_sticky", err, 1);

    // Backpressure holds output stable; async reset mid-operation clears everything.
    do_reset();
    out_rdy = 1'b0;
    send(8'h00, 3'd7);
    send(8'h01, 3'd7);
    in_val = 1'b0;
    check("bp_msg0", out_msg, mk(8'h00, 3'd7));
    check("bp_occ", occ, 2);
    cyc();
    cyc();
    check("bp_hold_val", out_val, 1);
    check("bp_hold_msg", out_msg, mk(8'h00, 3'd7));
    reset = 1'b0;
    #1;
    check("mid_rst_val", out_val, 0);
    check("mid_rst_occ", occ, 0);
    check("mid_rst_rdy", in_rdy, 0);
    cyc();
    reset = 1'b1;

    // exp_seq back at 0: 0x00 is the head. Bypass shows it in the same cycle.
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = mk(8'h00, 3'd2);
    #1;
`ifdef PLAB4_NET_REORDER_BYPASS_EN
    check("byp_same_val", out_val, 1);
    check("byp_same_msg", out_msg, mk(8'h00, 3'd2));
`else
    check("nobyp_same_val", out_val, 0);
`endif
    cyc();
    in_val = 1'b0;
`ifdef PLAB4_NET_REORDER_BYPASS_EN
    check("byp_occ", occ, 0);
    check("byp_next_val", out_val, 0);
`else
    check("nobyp_next_val", out_val, 1);
    check("nobyp_next_msg", out_msg, mk(8'h00, 3'd2));
    check("nobyp_occ", occ, 1);
`endif
    cyc();
    check("final_val", out_val, 0);
    check("final_occ", occ, 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
    $finish;
  end

endmodule
